// File: rtl/serdesphy_bringup_seq.sv
// SerDes PHY bring-up sequencer.
// Brings up the PLL (reset hold, then lock wait), optionally the CDR, and then
// holds the link ACTIVE while it tracks the lane-enable CSRs. A lock timeout
// retries from PLL_START up to MAX_RETRY times and then parks in FAULT.
// Ports:
//   clk, rst_n_in             : reference clock, async active-low reset
//   por_complete, phy_en      : bring-up permission (either low -> IDLE)
//   tx_en_csr, rx_en_csr      : CSR lane enables
//   pll_lock, cdr_lock        : lock indicators (already in the clk domain)
//   pll_en, pll_rst_n, cdr_en,
//   tx_en, rx_en              : registered analog controls
//   link_ready, fault         : registered status
//   seq_state, retry_cnt      : current state encoding and retries consumed
module serdesphy_bringup_seq #(
  parameter logic [7:0]  SETTLE_CYCLES = 8'd24,
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd2400,
  parameter logic [1:0]  MAX_RETRY     = 2'd2
) (
  input  logic       clk,
  input  logic       rst_n_in,
  input  logic       por_complete,
  input  logic       phy_en,
  input  logic       tx_en_csr,
  input  logic       rx_en_csr,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  output logic       pll_en,
  output logic       pll_rst_n,
  output logic       cdr_en,
  output logic       tx_en,
  output logic       rx_en,
  output logic       link_ready,
  output logic       fault,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_START = 3'd1,
    PLL_WAIT  = 3'd2,
    CDR_WAIT  = 3'd3,
    ACTIVE    = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic [1:0]  r_retry, w_retry_nxt;
  logic        r_pll_en, r_pll_rst_n, r_cdr_en, r_tx_en, r_rx_en, r_link_ready, r_fault;
  logic        w_pll_en, w_pll_rst_n, w_cdr_en, w_tx_en, w_rx_en, w_link_ready, w_fault;
  logic        w_fail;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = (r_timer != 16'd0) ? r_timer - 16'd1 : 16'd0;
    w_retry_nxt  = r_retry;
    w_pll_en     = r_pll_en;
    w_pll_rst_n  = r_pll_rst_n;
    w_cdr_en     = r_cdr_en;
    w_tx_en      = r_tx_en;
    w_rx_en      = r_rx_en;
    w_link_ready = r_link_ready;
    w_fault      = r_fault;
    w_fail       = 1'b0;

    if (r_state != IDLE && !(por_complete && phy_en)) begin
      w_state_nxt  = IDLE;
      w_timer_nxt  = 16'd0;
      w_retry_nxt  = 2'd0;
      w_pll_en     = 1'b0;
      w_pll_rst_n  = 1'b0;
      w_cdr_en     = 1'b0;
      w_tx_en      = 1'b0;
      w_rx_en      = 1'b0;
      w_link_ready = 1'b0;
      w_fault      = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_pll_en     = 1'b0;
          w_pll_rst_n  = 1'b0;
          w_cdr_en     = 1'b0;
          w_tx_en      = 1'b0;
          w_rx_en      = 1'b0;
          w_link_ready = 1'b0;
          w_fault      = 1'b0;
          w_timer_nxt  = 16'd0;
          if (por_complete && phy_en) begin
            w_state_nxt = PLL_START;
            w_pll_en    = 1'b1;
            w_timer_nxt = {8'd0, SETTLE_CYCLES};
          end
        end
        PLL_START: begin
          if (r_timer == 16'd0) begin
            w_state_nxt = PLL_WAIT;
            w_pll_rst_n = 1'b1;
            w_timer_nxt = LOCK_TIMEOUT;
          end
        end
        PLL_WAIT: begin
          // A lock seen in the timeout cycle still counts as success.
          if (pll_lock) begin
            w_tx_en = tx_en_csr;
            if (rx_en_csr) begin
              w_state_nxt = CDR_WAIT;
              w_cdr_en    = 1'b1;
              w_timer_nxt = LOCK_TIMEOUT;
            end else begin
              w_state_nxt  = ACTIVE;
              w_link_ready = 1'b1;
              w_retry_nxt  = 2'd0;
              w_timer_nxt  = 16'd0;
            end
          end else if (r_timer == 16'd0) begin
            w_fail = 1'b1;
          end
        end
        CDR_WAIT: begin
          if (cdr_lock) begin
            w_state_nxt  = ACTIVE;
            w_link_ready = 1'b1;
            w_retry_nxt  = 2'd0;
            w_timer_nxt  = 16'd0;
            w_tx_en      = tx_en_csr;
            w_rx_en      = rx_en_csr;
            w_cdr_en     = rx_en_csr;
          end else if (r_timer == 16'd0) begin
            w_fail = 1'b1;
          end
        end
        ACTIVE: begin
          if (!pll_lock) begin
            w_fail = 1'b1;
          end else if (!cdr_lock && rx_en_csr) begin
            // CDR-only relock: PLL stays up, tx keeps running.
            w_state_nxt  = CDR_WAIT;
            w_link_ready = 1'b0;
            w_rx_en      = 1'b0;
            w_cdr_en     = 1'b1;
            w_timer_nxt  = LOCK_TIMEOUT;
          end else begin
            w_tx_en  = tx_en_csr;
            w_rx_en  = rx_en_csr;
            w_cdr_en = rx_en_csr;
          end
        end
        FAULT: begin
          w_pll_en     = 1'b0;
          w_pll_rst_n  = 1'b0;
          w_cdr_en     = 1'b0;
          w_tx_en      = 1'b0;
          w_rx_en      = 1'b0;
          w_link_ready = 1'b0;
          w_fault      = 1'b1;
          w_timer_nxt  = 16'd0;
        end
        default: begin
          w_state_nxt  = IDLE;
          w_timer_nxt  = 16'd0;
          w_retry_nxt  = 2'd0;
          w_pll_en     = 1'b0;
          w_pll_rst_n  = 1'b0;
          w_cdr_en     = 1'b0;
          w_tx_en      = 1'b0;
          w_rx_en      = 1'b0;
          w_link_ready = 1'b0;
          w_fault      = 1'b0;
        end
      endcase

      // Shared failure path for lock timeouts and PLL loss in ACTIVE.
      if (w_fail) begin
        w_cdr_en     = 1'b0;
        w_tx_en      = 1'b0;
        w_rx_en      = 1'b0;
        w_link_ready = 1'b0;
        w_pll_rst_n  = 1'b0;
        if (r_retry < MAX_RETRY) begin
          w_state_nxt = PLL_START;
          w_retry_nxt = r_retry + 2'd1;
          w_pll_en    = 1'b1;
          w_timer_nxt = {8'd0, SETTLE_CYCLES};
        end else begin
          w_state_nxt = FAULT;
          w_pll_en    = 1'b0;
          w_fault     = 1'b1;
          w_timer_nxt = 16'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_timer      <= 16'd0;
      r_retry      <= 2'd0;
      r_pll_en     <= 1'b0;
      r_pll_rst_n  <= 1'b0;
      r_cdr_en     <= 1'b0;
      r_tx_en      <= 1'b0;
      r_rx_en      <= 1'b0;
      r_link_ready <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_retry      <= w_retry_nxt;
      r_pll_en     <= w_pll_en;
      r_pll_rst_n  <= w_pll_rst_n;
      r_cdr_en     <= w_cdr_en;
      r_tx_en      <= w_tx_en;
      r_rx_en      <= w_rx_en;
      r_link_ready <= w_link_ready;
      r_fault      <= w_fault;
    end
  end

  assign pll_en     = r_pll_en;
  assign pll_rst_n  = r_pll_rst_n;
  assign cdr_en     = r_cdr_en;
  assign tx_en      = r_tx_en;
  assign rx_en      = r_rx_en;
  assign link_ready = r_link_ready;
  assign fault      = r_fault;
  assign seq_state  = r_state;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_serdesphy_bringup_seq.sv
// Directed bench for serdesphy_bringup_seq with SETTLE_CYCLES=4,
// LOCK_TIMEOUT=20, MAX_RETRY=2. Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point.
module tb_serdesphy_bringup_seq;
  logic       clk = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       por_complete = 1'b0, phy_en = 1'b0;
  logic       tx_en_csr = 1'b0, rx_en_csr = 1'b0;
  logic       pll_lock = 1'b0, cdr_lock = 1'b0;
  logic       pll_en, pll_rst_n, cdr_en, tx_en, rx_en, link_ready, fault;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  serdesphy_bringup_seq #(
    .SETTLE_CYCLES(8'd4), .LOCK_TIMEOUT(16'd20), .MAX_RETRY(2'd2)
  ) dut (
    .clk(clk), .rst_n_in(rst_n_in), .por_complete(por_complete), .phy_en(phy_en),
    .tx_en_csr(tx_en_csr), .rx_en_csr(rx_en_csr), .pll_lock(pll_lock), .cdr_lock(cdr_lock),
    .pll_en(pll_en), .pll_rst_n(pll_rst_n), .cdr_en(cdr_en), .tx_en(tx_en), .rx_en(rx_en),
    .link_ready(link_ready), .fault(fault), .seq_state(seq_state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // {pll_en,pll_rst_n,cdr_en,tx_en,rx_en,link_ready,fault}
  function automatic logic [6:0] outs();
    return {pll_en, pll_rst_n, cdr_en, tx_en, rx_en, link_ready, fault};
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_state", {13'd0, seq_state}, 16'd0);
    chk("rst_outs", {9'd0, outs()}, 16'd0);
    chk("rst_retry", {14'd0, retry_cnt}, 16'd0);
    rst_n_in = 1'b1;
    step(2);
    chk("idle_wait", {13'd0, seq_state}, 16'd0);

    // Normal bring-up with CDR
    por_complete = 1'b1; phy_en = 1'b1; tx_en_csr = 1'b1; rx_en_csr = 1'b1;
    step(1);
    chk("start_state", {13'd0, seq_state}, 16'd1);
    chk("start_outs", {9'd0, outs()}, 16'b1000000);
    step(4);
    chk("rst_hold_5th", {13'd0, seq_state, pll_rst_n}, {13'd0, 3'd1, 1'b0});
    step(1);
    chk("pll_wait", {13'd0, seq_state, pll_rst_n}, {13'd0, 3'd2, 1'b1});
    step(9);
    pll_lock = 1'b1;
    step(1);
    chk("cdr_wait", {13'd0, seq_state}, 16'd3);
    chk("cdr_wait_outs", {9'd0, outs()}, 16'b1111000);
    step(4);
    cdr_lock = 1'b1;
    step(1);
    chk("active", {13'd0, seq_state}, 16'd4);
    chk("active_outs", {9'd0, outs()}, 16'b1111110);
    chk("active_retry", {14'd0, retry_cnt}, 16'd0);

    // CDR glitch in ACTIVE
    cdr_lock = 1'b0;
    step(1);
    chk("cdr_relock_st", {13'd0, seq_state}, 16'd3);
    chk("cdr_relock_out", {9'd0, outs()}, 16'b1111000);
    step(3);
    cdr_lock = 1'b1;
    step(1);
    chk("cdr_back", {13'd0, seq_state, link_ready}, {13'd0, 3'd4, 1'b1});
    chk("cdr_back_retry", {14'd0, retry_cnt}, 16'd0);

    // Async reset in CDR_WAIT
    cdr_lock = 1'b0;
    step(1);
    chk("pre_rst_st", {13'd0, seq_state}, 16'd3);
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_st", {13'd0, seq_state}, 16'd0);
    chk("async_outs", {9'd0, outs()}, 16'd0);
    pll_lock = 1'b0;
    step(1);
    #2 rst_n_in = 1'b1;
    step(1);
    chk("post_rst", {12'd0, seq_state, retry_cnt}, {12'd0, 3'd1, 2'd0});

    // PLL never locks: two retries then FAULT
    step(26);
    chk("retry1", {12'd0, seq_state, retry_cnt}, {12'd0, 3'd1, 2'd1});
    step(26);
    chk("retry2", {12'd0, seq_state, retry_cnt}, {12'd0, 3'd1, 2'd2});
    step(25);
    chk("last_wait", {13'd0, seq_state}, 16'd2);
    step(1);
    chk("fault_st", {13'd0, seq_state}, 16'd5);
    chk("fault_outs", {9'd0, outs()}, 16'b0000001);
    step(5);
    chk("fault_hold", {13'd0, seq_state}, 16'd5);
    phy_en = 1'b0;
    step(1);
    chk("fault_exit", {11'd0, seq_state, retry_cnt, fault}, 16'd0);

    // No RX: PLL_WAIT straight to ACTIVE, CDR/RX never enabled
    rx_en_csr = 1'b0; pll_lock = 1'b1; cdr_lock = 1'b0; phy_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("norx_cdr_rx", {14'd0, cdr_en, rx_en}, 16'd0);
    end
    chk("norx_wait", {13'd0, seq_state}, 16'd2);
    step(1);
    chk("norx_active", {13'd0, seq_state}, 16'd4);
    chk("norx_outs", {9'd0, outs()}, 16'b1101010);
    step(3);
    chk("norx_hold", {9'd0, outs()}, 16'b1101010);

    // PLL loss in ACTIVE counts as a retry
    pll_lock = 1'b0;
    step(1);
    chk("pll_loss_st", {12'd0, seq_state, retry_cnt}, {12'd0, 3'd1, 2'd1});
    chk("pll_loss_outs", {9'd0, outs()}, 16'b1000000);
    por_complete = 1'b0;
    step(1);
    chk("por_drop", {12'd0, seq_state, retry_cnt}, 16'd0);

    // Lock in the exact timeout cycle wins
    por_complete = 1'b1; rx_en_csr = 1'b1;
    step(26);
    chk("edge_wait", {13'd0, seq_state}, 16'd2);
    pll_lock = 1'b1;
    step(1);
    chk("edge_lock", {12'd0, seq_state, retry_cnt}, {12'd0, 3'd3, 2'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serdesphy_bringup_seq.md
SERDESPHY_BRINGUP_SEQ -- requirements
Module: serdesphy_bringup_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, 8'd24, number of PLL reset-hold countdown cycles (~1 us at 24 MHz).
REQ-002 SHALL have parameter LOCK_TIMEOUT, 16'd2400, number of PLL/CDR lock-wait countdown cycles (~100 us).
REQ-003 SHALL have parameter MAX_RETRY, 2'd2, number of lock-failure retries allowed before FAULT.
REQ-004 SHALL have port clk  input  1  24 MHz reference clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port por_complete  input  1  POR sequence done; digital and analog resets released.
REQ-007 SHALL have port phy_en  input  1  CSR PHY enable.
REQ-008 SHALL have port tx_en_csr / rx_en_csr  input  1 each  CSR lane enables.
REQ-009 SHALL have port pll_lock / cdr_lock  input  1 each  lock indicators, already synchronised to clk.
REQ-010 SHALL have port pll_en, pll_rst_n, cdr_en, tx_en, rx_en  output  1 each  analog block controls, all registered.
REQ-011 SHALL have port link_ready / fault  output  1 each  status flags, registered.
REQ-012 SHALL have port seq_state  output  3  current state: IDLE=0, PLL_START=1, PLL_WAIT=2, CDR_WAIT=3, ACTIVE=4, FAULT=5.
REQ-013 SHALL have port retry_cnt  output  2  count of retries consumed.

Function
REQ-014 SHALL use a 16-bit down-counter timer; a load takes effect in the cycle it is written, and each cycle in which the timer is nonzero and no transition occurs SHALL decrement it by 1.
REQ-015 SHALL, when por_complete=0 or phy_en=0 in any state other than IDLE, enter IDLE on the next edge with all outputs 0 and retry_cnt=0; this rule has highest priority.
REQ-016 SHALL in IDLE drive all enables, link_ready and fault to 0; when por_complete=1 and phy_en=1 it SHALL go to PLL_START with pll_en=1, pll_rst_n=0 and timer=SETTLE_CYCLES.
REQ-017 SHALL in PLL_START, on timer==0, set pll_rst_n=1, load timer=LOCK_TIMEOUT and go to PLL_WAIT; pll_rst_n SHALL therefore stay low for SETTLE_CYCLES+1 cycles.
REQ-018 SHALL in PLL_WAIT, on pll_lock=1, set tx_en=tx_en_csr, then:
- if rx_en_csr=1: set cdr_en=1, load timer=LOCK_TIMEOUT, go to CDR_WAIT.
- otherwise: go directly to ACTIVE.
REQ-019 SHALL in CDR_WAIT, on cdr_lock=1, go to ACTIVE.
REQ-020 SHALL treat timer==0 without the awaited lock, in PLL_WAIT or CDR_WAIT, as a failure.
REQ-021 SHALL handle a failure as follows:
- if retry_cnt<MAX_RETRY: increment retry_cnt, go to PLL_START with pll_en=1, pll_rst_n=0, cdr_en=0, tx_en=0, timer=SETTLE_CYCLES.
- otherwise: go to FAULT.
REQ-022 SHALL let an awaited lock that is high in the same cycle as timer==0 win over the failure path.
REQ-023 SHALL on entry to ACTIVE set link_ready=1 and clear retry_cnt to 0.
REQ-024 SHALL in ACTIVE track the CSRs each cycle: tx_en=tx_en_csr, rx_en=rx_en_csr, cdr_en=rx_en_csr.
REQ-025 SHALL in ACTIVE, on pll_lock=0, drop link_ready, tx_en, rx_en and cdr_en, and go to PLL_START as a retry counted per REQ-021.
REQ-026 SHALL in ACTIVE, on cdr_lock=0 while rx_en_csr=1 and pll_lock=1, drop link_ready and rx_en, load timer=LOCK_TIMEOUT and go to CDR_WAIT.
REQ-027 SHALL in FAULT drive fault=1 and all enables 0; FAULT SHALL exit only via REQ-015.
REQ-028 SHALL recover an illegal state encoding (6,7) to IDLE on the next edge.
REQ-029 SHALL assert rx_en only in ACTIVE.

Reset
REQ-030 SHALL, while rst_n_in=0, asynchronously force state=IDLE, timer=0, retry_cnt=0 and all outputs 0, with pll_rst_n=0.
REQ-031 SHALL on rst_n_in deassertion wait in IDLE for the REQ-016 conditions; reset asserted mid-sequence SHALL abort immediately with no partial output state.

Verification (SETTLE_CYCLES=4, LOCK_TIMEOUT=20, MAX_RETRY=2)
REQ-032 SHALL cover: por_complete=phy_en=1, pll_lock rises 10 cycles after pll_rst_n=1, cdr_lock 5 cycles later, tx/rx_en_csr=1 -> seq_state 1,2,3,4; pll_rst_n low 5 cycles; link_ready=1; tx_en=rx_en=1.
REQ-033 SHALL cover: pll_lock never rises -> 3 PLL_START entries, retry_cnt 1 then 2, then seq_state=5 and fault=1; phy_en=0 -> IDLE with fault=0.
REQ-034 SHALL cover: rx_en_csr=0, pll_lock=1 -> PLL_WAIT goes directly to ACTIVE; cdr_en=0 and rx_en=0 throughout.
REQ-035 SHALL cover: in ACTIVE, pulse cdr_lock low -> CDR_WAIT, link_ready=0; cdr_lock restored within 20 cycles -> ACTIVE, retry_cnt=0.
REQ-036 SHALL cover: pll_lock rising in the exact cycle the PLL_WAIT timer reaches 0 -> CDR_WAIT, retry_cnt unchanged.
REQ-037 SHALL cover: rst_n_in pulsed low in CDR_WAIT -> all outputs 0 asynchronously; after release, restart from IDLE with retry_cnt=0.
